// File: rtl/aclk_key_entry_if.sv
// Keypad entry bus: key/button/tick inputs toward the sequencer and the
// staged HH:MM value plus load/status strobes back out.
interface aclk_key_entry_if;
    logic       one_second;
    logic       key_valid;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] new_ms_hr;
    logic [3:0] new_ls_hr;
    logic [3:0] new_ms_min;
    logic [3:0] new_ls_min;
    logic       load_new_a;
    logic       load_new_c;
    logic       entry_active;
    logic [2:0] digit_count;
    logic       key_err;

    modport master (
        output one_second, key_valid, key, alarm_button, time_button,
        input  new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
        input  load_new_a, load_new_c, entry_active, digit_count, key_err
    );

    modport slave (
        input  one_second, key_valid, key, alarm_button, time_button,
        output new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
        output load_new_a, load_new_c, entry_active, digit_count, key_err
    );
endinterface

// File: rtl/aclk_key_entry.sv
// Keypad digit-entry sequencer: shifts BCD digits into an HH:MM buffer and
// commits it to the alarm or clock. Define ACLK_ENTRY_VALIDATE_EN to range-check commits.
module aclk_key_entry #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input logic            clk,
    input logic            reset_n,
    aclk_key_entry_if.slave kif
);
    typedef enum logic [1:0] {IDLE, ENTRY, LOAD_A, LOAD_C} state_t;

    localparam logic [5:0] TMO = 6'(TIMEOUT_SEC);

    state_t      state_q;
    logic [15:0] buf_q;
    logic [2:0]  cnt_q;
    logic [5:0]  timer_q;
    logic        load_a_q;
    logic        load_c_q;
    logic        err_q;
    logic        active_q;

    logic        is_digit_d;
    logic        is_clear_d;
    logic [15:0] shift_d;
    logic [2:0]  cnt_d;
    logic [5:0]  timer_d;
    logic        tmo_d;

`ifdef ACLK_ENTRY_VALIDATE_EN
    function automatic logic time_ok(input logic [15:0] b);
        return (b[15:12] <= 4'd2) && (b[15:8] <= 8'h23) && (b[11:8] <= 4'd9)
            && (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
    endfunction
`endif

    assign is_digit_d = kif.key_valid && (kif.key <= 4'd9);
    assign is_clear_d = kif.key_valid && (kif.key == 4'hA);
    assign shift_d    = {buf_q[11:0], kif.key};
    assign cnt_d      = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
    assign timer_d    = timer_q + 6'd1;
    // A tick that would bring the idle-key timer to the limit ends the entry.
    assign tmo_d      = kif.one_second && (timer_d >= TMO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            load_a_q <= 1'b0;
            load_c_q <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            load_a_q <= 1'b0;
            load_c_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_digit_d) begin
                        buf_q    <= {12'h000, kif.key};
                        cnt_q    <= 3'd1;
                        timer_q  <= '0;
                        active_q <= 1'b1;
                        state_q  <= ENTRY;
                    end
                end
                ENTRY: begin
                    // Any key strobe owns the cycle: buttons and timeout are not looked at.
                    if (kif.key_valid) begin
                        if (is_digit_d) begin
                            buf_q   <= shift_d;
                            cnt_q   <= cnt_d;
                            timer_q <= '0;
                        end else if (is_clear_d) begin
                            buf_q   <= '0;
                            cnt_q   <= '0;
                            timer_q <= '0;
                        end
                    end else if (tmo_d) begin
                        buf_q    <= '0;
                        cnt_q    <= '0;
                        timer_q  <= '0;
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        if (kif.one_second) timer_q <= timer_d;
                        if (kif.alarm_button || kif.time_button) begin
                            if ((kif.alarm_button && kif.time_button) || (cnt_q != 3'd4)) begin
                                err_q <= 1'b1;
`ifdef ACLK_ENTRY_VALIDATE_EN
                            end else if (!time_ok(buf_q)) begin
                                err_q    <= 1'b1;
                                buf_q    <= '0;
                                cnt_q    <= '0;
                                timer_q  <= '0;
                                active_q <= 1'b0;
                                state_q  <= IDLE;
`endif
                            end else begin
                                cnt_q    <= '0;
                                timer_q  <= '0;
                                active_q <= 1'b0;
                                load_a_q <= kif.alarm_button;
                                load_c_q <= kif.time_button;
                                state_q  <= kif.alarm_button ? LOAD_A : LOAD_C;
                            end
                        end
                    end
                end
                LOAD_A, LOAD_C: state_q <= IDLE;
                default:        state_q <= IDLE;
            endcase
        end
    end

    assign kif.new_ms_hr    = buf_q[15:12];
    assign kif.new_ls_hr    = buf_q[11:8];
    assign kif.new_ms_min   = buf_q[7:4];
    assign kif.new_ls_min   = buf_q[3:0];
    assign kif.load_new_a   = load_a_q;
    assign kif.load_new_c   = load_c_q;
    assign kif.entry_active = active_q;
    assign kif.digit_count  = cnt_q;
    assign kif.key_err      = err_q;
endmodule

// File: tb/tb_aclk_key_entry.sv
// Directed bench for aclk_key_entry: table of single-cycle vectors plus
// hand sequences for timeout, commit validation and asynchronous reset.
module tb_aclk_key_entry;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic        kv;
        logic [3:0]  k;
        logic        ab;
        logic        tb;
        logic        os;
        logic [22:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    aclk_key_entry_if kif ();

    aclk_key_entry #(.TIMEOUT_SEC(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kif     (kif)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] ex(input logic [15:0] b, input logic la, input logic lc,
                                       input logic act, input logic [2:0] c, input logic err);
        return {b, la, lc, act, c, err};
    endfunction

    function automatic vec_t mk(input logic kv, input logic [3:0] k, input logic ab,
                                input logic tb, input logic os, input logic [22:0] e);
        vec_t v;
        v.kv = kv; v.k = k; v.ab = ab; v.tb = tb; v.os = os; v.exp = e;
        return v;
    endfunction

    function automatic logic [22:0] actual();
        return {kif.new_ms_hr, kif.new_ls_hr, kif.new_ms_min, kif.new_ls_min,
                kif.load_new_a, kif.load_new_c, kif.entry_active, kif.digit_count, kif.key_err};
    endfunction

    task automatic compare(input string nm, input logic [22:0] e);
        logic [22:0] a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got buf=%h la=%b lc=%b act=%b cnt=%0d err=%b, want buf=%h la=%b lc=%b act=%b cnt=%0d err=%b",
                     nm, a[22:7], a[6], a[5], a[4], a[3:1], a[0],
                     e[22:7], e[6], e[5], e[4], e[3:1], e[0]);
        end
    endtask

    task automatic cyc(input string nm, input vec_t v);
        @(negedge clk);
        kif.key_valid    = v.kv;
        kif.key          = v.k;
        kif.alarm_button = v.ab;
        kif.time_button  = v.tb;
        kif.one_second   = v.os;
        @(posedge clk);
        #1;
        compare(nm, v.exp);
    endtask

    vec_t tbl [0:24];

    initial begin
        kif.key_valid = 1'b0; kif.key = 4'h0; kif.alarm_button = 1'b0;
        kif.time_button = 1'b0; kif.one_second = 1'b0;

        // alarm commit 1,2,3,4
        tbl[0]  = mk(H, 4'h1, L, L, L, ex(16'h0001, L, L, H, 3'd1, L));
        tbl[1]  = mk(H, 4'h2, L, L, L, ex(16'h0012, L, L, H, 3'd2, L));
        tbl[2]  = mk(H, 4'h3, L, L, L, ex(16'h0123, L, L, H, 3'd3, L));
        tbl[3]  = mk(H, 4'h4, L, L, L, ex(16'h1234, L, L, H, 3'd4, L));
        tbl[4]  = mk(L, 4'h0, H, L, L, ex(16'h1234, H, L, L, 3'd0, L));
        tbl[5]  = mk(L, 4'h0, L, L, L, ex(16'h1234, L, L, L, 3'd0, L));
        // overflow, clear, short commit
        tbl[6]  = mk(H, 4'h9, L, L, L, ex(16'h0009, L, L, H, 3'd1, L));
        tbl[7]  = mk(H, 4'h1, L, L, L, ex(16'h0091, L, L, H, 3'd2, L));
        tbl[8]  = mk(H, 4'h2, L, L, L, ex(16'h0912, L, L, H, 3'd3, L));
        tbl[9]  = mk(H, 4'h3, L, L, L, ex(16'h9123, L, L, H, 3'd4, L));
        tbl[10] = mk(H, 4'h4, L, L, L, ex(16'h1234, L, L, H, 3'd4, L));
        tbl[11] = mk(H, 4'hA, L, L, L, ex(16'h0000, L, L, H, 3'd0, L));
        tbl[12] = mk(L, 4'h0, L, H, L, ex(16'h0000, L, L, H, 3'd0, H));
        tbl[13] = mk(L, 4'h0, L, L, L, ex(16'h0000, L, L, H, 3'd0, L));
        // collisions
        tbl[14] = mk(H, 4'h5, L, L, L, ex(16'h0005, L, L, H, 3'd1, L));
        tbl[15] = mk(H, 4'h6, L, L, L, ex(16'h0056, L, L, H, 3'd2, L));
        tbl[16] = mk(H, 4'h7, L, L, L, ex(16'h0567, L, L, H, 3'd3, L));
        tbl[17] = mk(H, 4'h8, L, L, L, ex(16'h5678, L, L, H, 3'd4, L));
        tbl[18] = mk(L, 4'h0, H, H, L, ex(16'h5678, L, L, H, 3'd4, H));
        tbl[19] = mk(H, 4'h1, H, L, L, ex(16'h6781, L, L, H, 3'd4, L));
        tbl[20] = mk(L, 4'h0, L, H, L, ex(16'h6781, L, H, L, 3'd0, L));
        tbl[21] = mk(L, 4'h0, L, L, L, ex(16'h6781, L, L, L, 3'd0, L));
        // ignored inputs in IDLE
        tbl[22] = mk(H, 4'hB, L, L, L, ex(16'h6781, L, L, L, 3'd0, L));
        tbl[23] = mk(L, 4'h0, H, H, H, ex(16'h6781, L, L, L, 3'd0, L));
        tbl[24] = mk(H, 4'hA, L, L, L, ex(16'h6781, L, L, L, 3'd0, L));

        #12;
        compare("reset_state", ex(16'h0000, L, L, L, 3'd0, L));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) cyc($sformatf("vec%0d", i), tbl[i]);

        // timeout: keys 0,7 then ticks; a key on the 10th tick restarts the count
        cyc("to_k0", mk(H, 4'h0, L, L, L, ex(16'h0000, L, L, H, 3'd1, L)));
        cyc("to_k7", mk(H, 4'h7, L, L, L, ex(16'h0007, L, L, H, 3'd2, L)));
        for (int i = 1; i <= 9; i++)
            cyc($sformatf("to_tick%0d", i), mk(L, 4'h0, L, L, H, ex(16'h0007, L, L, H, 3'd2, L)));
        cyc("to_key_tick", mk(H, 4'h5, L, L, H, ex(16'h0075, L, L, H, 3'd3, L)));
        for (int i = 1; i <= 9; i++)
            cyc($sformatf("to_retick%0d", i), mk(L, 4'h0, L, L, H, ex(16'h0075, L, L, H, 3'd3, L)));
        cyc("to_expire", mk(L, 4'h0, L, L, H, ex(16'h0000, L, L, L, 3'd0, L)));
        cyc("to_after", mk(L, 4'h0, L, L, L, ex(16'h0000, L, L, L, 3'd0, L)));

        // commit validation: 24:00 then 23:59
        cyc("va_k2", mk(H, 4'h2, L, L, L, ex(16'h0002, L, L, H, 3'd1, L)));
        cyc("va_k4", mk(H, 4'h4, L, L, L, ex(16'h0024, L, L, H, 3'd2, L)));
        cyc("va_k0a", mk(H, 4'h0, L, L, L, ex(16'h0240, L, L, H, 3'd3, L)));
        cyc("va_k0b", mk(H, 4'h0, L, L, L, ex(16'h2400, L, L, H, 3'd4, L)));
`ifdef ACLK_ENTRY_VALIDATE_EN
        cyc("va_2400", mk(L, 4'h0, L, H, L, ex(16'h0000, L, L, L, 3'd0, H)));
        cyc("va_2400_after", mk(L, 4'h0, L, L, L, ex(16'h0000, L, L, L, 3'd0, L)));
`else
        cyc("va_2400", mk(L, 4'h0, L, H, L, ex(16'h2400, L, H, L, 3'd0, L)));
        cyc("va_2400_after", mk(L, 4'h0, L, L, L, ex(16'h2400, L, L, L, 3'd0, L)));
`endif
        cyc("vb_k2", mk(H, 4'h2, L, L, L, ex(16'h0002, L, L, H, 3'd1, L)));
        cyc("vb_k3", mk(H, 4'h3, L, L, L, ex(16'h0023, L, L, H, 3'd2, L)));
        cyc("vb_k5", mk(H, 4'h5, L, L, L, ex(16'h0235, L, L, H, 3'd3, L)));
        cyc("vb_k9", mk(H, 4'h9, L, L, L, ex(16'h2359, L, L, H, 3'd4, L)));
        cyc("vb_2359", mk(L, 4'h0, L, H, L, ex(16'h2359, L, H, L, 3'd0, L)));
        cyc("vb_after", mk(L, 4'h0, L, H, L, ex(16'h2359, L, L, L, 3'd0, L)));

        // asynchronous reset in the middle of an entry
        cyc("rs_k1", mk(H, 4'h1, L, L, L, ex(16'h0001, L, L, H, 3'd1, L)));
        cyc("rs_k2", mk(H, 4'h2, L, L, L, ex(16'h0012, L, L, H, 3'd2, L)));
        @(negedge clk);
        kif.key_valid = 1'b0; kif.alarm_button = 1'b0; kif.time_button = 1'b0; kif.one_second = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        compare("rs_async", ex(16'h0000, L, L, L, 3'd0, L));
        @(negedge clk);
        reset_n = 1'b1;
        cyc("rs_rel1", mk(L, 4'h0, H, L, L, ex(16'h0000, L, L, L, 3'd0, L)));
        cyc("rs_rel2", mk(L, 4'h0, L, H, L, ex(16'h0000, L, L, L, 3'd0, L)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
